dave_tones: RTL and testbench
=============================

DAVE_TONES -- requirements
Module: dave_tones

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: cecpu  in  1  CPU bus clock enable; bus writes sampled only when high.
REQ-004 SHALL have ports: ceirq  in  1  tick enable for counters (250 kHz rate).
REQ-005 SHALL have ports: iorq  in  1  active-low I/O request.
REQ-006 SHALL have ports: wr  in  1  active-low write strobe.
REQ-007 SHALL have ports: a  in  8  I/O address (low byte).
REQ-008 SHALL have ports: d  in  8  write data.
REQ-009 SHALL have ports: tone  out  3  per-channel square wave, channels 0..2.
REQ-010 SHALL have ports: irq0  out  1  channel-0 reload pulse, one ceirq period wide.
REQ-011 SHALL have ports: irq1  out  1  channel-1 reload pulse, one ceirq period wide.
REQ-012 SHALL use parameter: none; constants live in the package.

Function
REQ-013 A write is qualified only when cecpu=1, iorq=0 and wr=0.
REQ-014 Port A0/A2/A4 write: latch d[7:0] into period[7:0] of channel 0/1/2.
REQ-015 Port A1/A3/A5 write: latch d[3:0] into period[11:8] of channel 0/1/2; d[7:4] ignored.
REQ-016 Port A7 write: latch d[0] into sync; other bits ignored by this block.
REQ-017 Each channel holds a 12-bit down-counter cnt and a tone flip-flop.
REQ-018 On ceirq with sync=0: if cnt==0, cnt<=period and tone toggles; else cnt<=cnt-1.
REQ-019 Resulting tone frequency SHALL be f(ceirq)/(2*(period+1)).
REQ-020 period=0 SHALL reload on every tick, so tone toggles on each ceirq.
REQ-021 A period write SHALL NOT disturb cnt; the new value takes effect at the next reload.
REQ-022 While sync=1: cnt<=period on every ceirq, tone<=0, and irq0/irq1<=0.
REQ-023 On the first ceirq after sync returns to 0, counting resumes from the loaded period with no reload event on that tick.
REQ-024 irq0/irq1 are registered on ceirq: 1 if channel 0/1 reloaded on that tick, else 0.
REQ-025 irq0/irq1 are held between ceirq strobes, giving exactly one ceirq period high per reload.
REQ-026 When cecpu and ceirq coincide: both act in the same cycle. The write updates its register; the reload on that tick uses the pre-write period.
REQ-027 Writes to any other address SHALL have no effect.
REQ-028 The block provides no readback; all registers are write-only.

Reset
REQ-029 reset=0 SHALL asynchronously clear period, cnt, sync, tone[2:0], irq0 and irq1 to 0.
REQ-030 Reset asserted mid-count SHALL abandon the count. After release, each channel with period 0 toggles on each ceirq until reprogrammed.

Structure
REQ-031 Package dave_pkg SHALL hold the port address constants (A0..A5, A7), the 12-bit period width, and the channel count of 3.
REQ-032 One sub-module, dave_tone_channel, SHALL contain the counter, tone flip-flop and reload pulse. It is instantiated three times.
REQ-033 Address decode and register write logic SHALL stay in dave_tones.

Verification
REQ-034 Write A0=0x04, A1=0x00, then 20 ceirq ticks -> tone[0] toggles every 5 ticks; irq0 is high 1 tick in every 5.
REQ-035 Write A2=0xFF, A3=0x0F -> channel 1 reloads after 4096 ticks; irq1 pulses once; d[7:4] of the A3 write has no observable effect.
REQ-036 Write A7=0x01 while counting, hold 10 ticks, then write A7=0x00 -> during sync, tone=0 and no irq. The first reload after sync occurs period+1 ticks after release.
REQ-037 With cnt=0 on channel 0, write A0=0x09 in the same cycle as ceirq -> the reload uses the old period; the following reload uses 9.
REQ-038 Assert reset mid-count on all channels -> all outputs are 0 immediately; after release, tone[0..2] toggle every tick.
REQ-039 Write to address A6 or with iorq=1 -> no register changes and tone timing is unaffected.

Source files
------------

// File: rtl/dave_pkg.sv
// dave_pkg: port addresses, period width and channel count shared by the tone block.
package dave_pkg;
  localparam int NUM_CH = 3;
  localparam int PERIOD_W = 12;
  typedef logic [PERIOD_W-1:0] period_t;
  localparam logic [7:0] PORT_A0 = 8'hA0;
  localparam logic [7:0] PORT_A1 = 8'hA1;
  localparam logic [7:0] PORT_A2 = 8'hA2;
  localparam logic [7:0] PORT_A3 = 8'hA3;
  localparam logic [7:0] PORT_A4 = 8'hA4;
  localparam logic [7:0] PORT_A5 = 8'hA5;
  localparam logic [7:0] PORT_A7 = 8'hA7;
  localparam logic [7:0] PORT_LO [NUM_CH] = '{PORT_A0, PORT_A2, PORT_A4};
  localparam logic [7:0] PORT_HI [NUM_CH] = '{PORT_A1, PORT_A3, PORT_A5};
endpackage

// File: rtl/dave_tones_if.sv
// dave_tones_if: CPU I/O write bus feeding the tone block.
interface dave_tones_if;
  logic       cecpu;
  logic       iorq;
  logic       wr;
  logic [7:0] a;
  logic [7:0] d;
  modport master (output cecpu, iorq, wr, a, d);
  modport slave  (input  cecpu, iorq, wr, a, d);
endinterface

// File: rtl/dave_tone_channel.sv
// dave_tone_channel: 12-bit reload down-counter, tone flip-flop and reload pulse.
module dave_tone_channel
  import dave_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    ceirq,
  input  logic    sync,
  input  period_t period,
  output logic    tone,
  output logic    irq
);
  period_t cnt_q, cnt_d;
  logic    tone_q, tone_d, irq_q, irq_d, zero;
  assign zero = cnt_q == '0;
  // sync holds the counter at the period so release restarts a full period
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    irq_d  = irq_q;
    if (ceirq) begin
      cnt_d  = (sync || zero) ? period : cnt_q - period_t'(1);
      tone_d = sync ? 1'b0 : tone_q ^ zero;
      irq_d  = ~sync & zero;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
      irq_q  <= irq_d;
    end
  assign tone = tone_q;
  assign irq  = irq_q;
endmodule

// File: rtl/dave_tones.sv
// dave_tones: three square-wave tone channels programmed through write-only I/O ports.
module dave_tones
  import dave_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               ceirq,
  dave_tones_if.slave        bus,
  output logic [NUM_CH-1:0]  tone,
  output logic               irq0,
  output logic               irq1
);
  period_t           period_q [NUM_CH];
  period_t           period_d [NUM_CH];
  logic              sync_q, sync_d, wr_en;
  logic [NUM_CH-1:0] irq_w;
  assign wr_en = bus.cecpu & ~bus.iorq & ~bus.wr;
  always_comb begin
    period_d = period_q;
    sync_d   = sync_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && bus.a == PORT_LO[i]) period_d[i][7:0]  = bus.d;
      if (wr_en && bus.a == PORT_HI[i]) period_d[i][11:8] = bus.d[3:0];
    end
    if (wr_en && bus.a == PORT_A7) sync_d = bus.d[0];
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) period_q[i] <= '0;
      sync_q <= 1'b0;
    end else begin
      period_q <= period_d;
      sync_q   <= sync_d;
    end
  // channels see the registered period, so a coincident write affects only later reloads
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dave_tone_channel u_ch (
      .clock  (clock),
      .reset  (reset),
      .ceirq  (ceirq),
      .sync   (sync_q),
      .period (period_q[c]),
      .tone   (tone[c]),
      .irq    (irq_w[c])
    );
  end
  assign irq0 = irq_w[0];
  assign irq1 = irq_w[1];
endmodule

// File: tb/tb_dave_tones.sv
// tb_dave_tones: table, directed and random checks of dave_tones against a period/countdown model.
module tb_dave_tones;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ceirq = 1'b0;
  logic [2:0] tone;
  logic       irq0, irq1;
  int         n_checks = 0, n_fail = 0, gap_max = 1;
  dave_tones_if bus();
  dave_tones dut (.clock(clock), .reset(reset), .ceirq(ceirq), .bus(bus), .tone(tone), .irq0(irq0), .irq1(irq1));
  always #5 clock = ~clock;

  int m_per [3], m_left [3];
  bit m_tone [3], m_irq [2], m_sync;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < 3; c++) begin
      m_per[c] = 0; m_left[c] = 0; m_tone[c] = 0;
    end
    m_irq[0] = 0; m_irq[1] = 0; m_sync = 0;
  endfunction

  function automatic void model_cycle(input logic [7:0] addr, input logic [7:0] data, input bit write, input bit tk);
    if (tk)
      for (int c = 0; c < 3; c++) begin
        bit rel = !m_sync && m_left[c] == 0;
        if (m_sync) begin m_left[c] = m_per[c]; m_tone[c] = 0; end
        else if (rel) begin m_left[c] = m_per[c]; m_tone[c] = !m_tone[c]; end
        else m_left[c] = m_left[c] - 1;
        if (c < 2) m_irq[c] = rel;
      end
    if (write)
      case (addr)
        8'hA0: m_per[0] = (m_per[0] & 'hF00) | int'(data);
        8'hA2: m_per[1] = (m_per[1] & 'hF00) | int'(data);
        8'hA4: m_per[2] = (m_per[2] & 'hF00) | int'(data);
        8'hA1: m_per[0] = (m_per[0] & 'hFF) | ((int'(data) & 'hF) << 8);
        8'hA3: m_per[1] = (m_per[1] & 'hFF) | ((int'(data) & 'hF) << 8);
        8'hA5: m_per[2] = (m_per[2] & 'hFF) | ((int'(data) & 'hF) << 8);
        8'hA7: m_sync = data[0];
        default: ;
      endcase
  endfunction

  task automatic step(input logic [7:0] addr, input logic [7:0] data, input logic wr_n, input logic iorq_n, input logic ce, input logic tk);
    bus.a = addr; bus.d = data; bus.wr = wr_n; bus.iorq = iorq_n; bus.cecpu = ce; ceirq = tk;
    @(posedge clock);
    model_cycle(addr, data, ce && !iorq_n && !wr_n, tk);
    @(negedge clock);
    bus.wr = 1'b1; bus.iorq = 1'b1; bus.cecpu = 1'b0; ceirq = 1'b0;
    check("tone", int'(tone), {m_tone[2], m_tone[1], m_tone[0]});
    check("irq", int'({irq1, irq0}), {m_irq[1], m_irq[0]});
  endtask

  task automatic tick();
    step(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat ($urandom_range(gap_max, 0)) step(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wr_port(input logic [7:0] addr, input logic [7:0] data);
    step(addr, data, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    #1;
    check("reset_tone", int'(tone), 0);
    check("reset_irq", int'({irq1, irq0}), 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic ticks_to_irq(input int ch, output int n);
    n = -1;
    for (int i = 1; i <= 5000; i++) begin
      tick();
      if ((ch == 0 ? irq0 : irq1) === 1'b1) begin n = i; break; end
    end
  endtask

  typedef struct {
    logic [7:0] lo_addr;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       iorq_n;
    int         ticks;
    int         exp_reloads;
  } vec_t;

  initial begin
    vec_t vt [7];
    int n, toggles, pulses, bad;
    bit prev;
    bus.a = 0; bus.d = 0; bus.wr = 1; bus.iorq = 1; bus.cecpu = 0;
    model_clear();
    #1;
    check("por_tone", int'(tone), 0);
    check("por_irq", int'({irq1, irq0}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    vt[0] = '{8'hA0, 8'h04, 8'h00, 1'b0, 20, 4};
    vt[1] = '{8'hA0, 8'h00, 8'h00, 1'b0, 10, 10};
    vt[2] = '{8'hA0, 8'h02, 8'h10, 1'b0, 9, 3};
    vt[3] = '{8'hA0, 8'h07, 8'hF0, 1'b0, 17, 3};
    vt[4] = '{8'hA0, 8'h01, 8'h00, 1'b0, 6, 3};
    vt[5] = '{8'hA6, 8'h04, 8'h00, 1'b0, 5, 5};
    vt[6] = '{8'hA0, 8'h04, 8'h00, 1'b1, 5, 5};
    for (int v = 0; v < 7; v++) begin
      do_reset();
      step(vt[v].lo_addr, vt[v].lo, 1'b0, vt[v].iorq_n, 1'b1, 1'b0);
      step(8'hA1, vt[v].hi, 1'b0, vt[v].iorq_n, 1'b1, 1'b0);
      toggles = 0; pulses = 0;
      for (int t = 0; t < vt[v].ticks; t++) begin
        prev = tone[0];
        tick();
        if (tone[0] != prev) toggles++;
        if (irq0) pulses++;
      end
      check($sformatf("vec%0d_toggles", v), toggles, vt[v].exp_reloads);
      check($sformatf("vec%0d_irq0", v), pulses, vt[v].exp_reloads);
    end

    gap_max = 0;
    do_reset();
    wr_port(8'hA2, 8'hFF);
    wr_port(8'hA3, 8'h1F);
    ticks_to_irq(1, n);
    check("ch1_first_reload", n, 1);
    ticks_to_irq(1, n);
    check("ch1_full_period", n, 4096);
    gap_max = 1;

    do_reset();
    wr_port(8'hA0, 8'h04);
    repeat (7) tick();
    wr_port(8'hA7, 8'h01);
    bad = 0;
    repeat (10) begin
      tick();
      if (tone != 3'b000 || irq0 || irq1) bad++;
    end
    check("sync_quiet", bad, 0);
    wr_port(8'hA7, 8'h00);
    ticks_to_irq(0, n);
    check("sync_release_reload", n, 5);

    do_reset();
    wr_port(8'hA0, 8'h03);
    repeat (4) tick();
    step(8'hA0, 8'h09, 1'b0, 1'b0, 1'b1, 1'b1);
    check("coincide_reload", int'(irq0), 1);
    ticks_to_irq(0, n);
    check("coincide_old_period", n, 4);
    ticks_to_irq(0, n);
    check("coincide_new_period", n, 10);

    wr_port(8'hA2, 8'h05);
    wr_port(8'hA4, 8'h07);
    repeat (3) tick();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("post_reset_tone%0d", k), int'(tone), (k % 2) ? 7 : 0);
    end

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] addr, data;
      int sel = $urandom_range(9, 0);
      addr = (sel < 6) ? 8'hA0 + 8'(sel) : (sel == 6) ? 8'hA7 : (sel == 7) ? 8'hA6 : (sel == 8) ? 8'h20 : 8'hB1;
      data = 8'($urandom);
      if (addr == 8'hA7) data = 8'(($urandom_range(3, 0) == 0) ? 1 : 0) | (data & 8'hFE);
      else if (addr[0]) data = ($urandom_range(3, 0) == 0) ? data : (data & 8'hF0);
      else data = ($urandom_range(3, 0) == 0) ? data : (data & 8'h0F);
      step(addr, data, 1'($urandom_range(2, 0) == 0), 1'($urandom_range(3, 0) == 0),
           1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
